instr_fetch_unit: RTL and testbench

//  Requester side of the instruction-memory interface: owns the program counter, drives the

---
 rtl/instr_fetch_unit.sv | 99 +++++++++
 tb/tb_instr_fetch_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction memory
// address and captures the returned word into the IF/ID register.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 256,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        if_valid,
    output logic        fetch_fault,
    output logic        misalign_pulse,
    output logic [31:0] fetch_count
);

    localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;

    typedef enum logic [2:0] {
        M_REDIR,
        M_FAULT,
        M_STALL,
        M_FETCH,
        M_OOR
    } mode_t;

    logic [31:0] pc;
    logic        in_range;
    mode_t       mode;

    assign imem_addr = pc;
    assign in_range  = ({1'b0, pc} < PC_LIMIT);

    // Redirect outranks everything, so a wrong-path word is killed
    // even while the pipeline is stalled or the fetch has faulted.
    always_comb begin
        mode = M_OOR;
        priority case (1'b1)
            redirect_valid: mode = M_REDIR;
            fetch_fault:    mode = M_FAULT;
            stall:          mode = M_STALL;
            in_range:       mode = M_FETCH;
            default:        mode = M_OOR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= RESET_PC;
            if_instr       <= NOP_WORD;
            if_pc          <= 32'd0;
            if_pc_plus4    <= 32'd0;
            if_valid       <= 1'b0;
            fetch_fault    <= 1'b0;
            misalign_pulse <= 1'b0;
            fetch_count    <= 32'd0;
        end else begin
            misalign_pulse <= 1'b0;
            unique case (mode)
                M_REDIR: begin
                    pc             <= {redirect_target[31:2], 2'b00};
                    if_instr       <= NOP_WORD;
                    if_valid       <= 1'b0;
                    fetch_fault    <= 1'b0;
                    misalign_pulse <= |redirect_target[1:0];
                end
                M_FAULT: begin
                    if_instr <= NOP_WORD;
                    if_valid <= 1'b0;
                end
                M_STALL: begin
                end
                M_FETCH: begin
                    if_instr    <= imem_instr;
                    if_pc       <= pc;
                    if_pc_plus4 <= pc + 32'd4;
                    if_valid    <= 1'b1;
                    pc          <= pc + 32'd4;
                    fetch_count <= fetch_count + 32'd1;
                end
                M_OOR: begin
                    fetch_fault <= 1'b1;
                    if_instr    <= NOP_WORD;
                    if_valid    <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a scoreboard queue holds
// the expected {word, pc} of each fetch and is checked at IF/ID.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        if_valid;
    logic        fetch_fault;
    logic        misalign_pulse;
    logic [31:0] fetch_count;

    logic [31:0] mem [256];
    logic [63:0] sb [$];
    logic [31:0] exp_pc;
    logic [31:0] exp_count;
    int          passed = 0;
    int          total = 0;

    instr_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .IMEM_WORDS(256),
        .NOP_WORD(32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_addr(imem_addr),
        .imem_instr(imem_instr),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .if_instr(if_instr),
        .if_pc(if_pc),
        .if_pc_plus4(if_pc_plus4),
        .if_valid(if_valid),
        .fetch_fault(fetch_fault),
        .misalign_pulse(misalign_pulse),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    assign imem_instr = (imem_addr < 32'd1024) ? mem[imem_addr[9:2]]
                                               : 32'hDEAD_BEEF;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        exp_pc = 32'd0;
        exp_count = 32'd0;
        sb.delete();
    endtask

    // Normal fetch cycles: predict each captured word, then check it.
    task automatic run_fetch(input int n);
        logic [63:0] e;
        for (int i = 0; i < n; i++) begin
            sb.push_back({mem[exp_pc[9:2]], exp_pc});
            exp_pc = exp_pc + 32'd4;
            exp_count = exp_count + 32'd1;
            step();
            total++;
            if (sb.size() == 0) begin
                $display("FAIL sb_empty: scoreboard had no entry");
            end else begin
                e = sb.pop_front();
                if ({if_valid, if_instr, if_pc, if_pc_plus4} !==
                    {1'b1, e[63:32], e[31:0], e[31:0] + 32'd4})
                    $display("FAIL fetch: got v=%0b instr=%h pc=%h pc4=%h want instr=%h pc=%h",
                             if_valid, if_instr, if_pc, if_pc_plus4, e[63:32], e[31:0]);
                else passed++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        total++;
        if ({imem_addr, if_instr, if_pc, if_pc_plus4, if_valid,
             fetch_fault, misalign_pulse, fetch_count} !== '0)
            $display("FAIL reset_state: addr=%h instr=%h pc=%h v=%0b flt=%0b cnt=%0d want all 0",
                     imem_addr, if_instr, if_pc, if_valid, fetch_fault, fetch_count);
        else passed++;
    endtask

    task automatic test_free_run();
        do_reset();
        run_fetch(5);
        total++;
        if (fetch_count !== 32'd5)
            $display("FAIL free_run_count: got %0d want 5", fetch_count);
        else passed++;
        total++;
        if (imem_addr !== 32'd20)
            $display("FAIL free_run_addr: got %h want 14", imem_addr);
        else passed++;
    endtask

    task automatic test_stall();
        do_reset();
        run_fetch(2);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({imem_addr, if_pc, if_instr, fetch_count, if_valid} !==
                {32'd8, 32'd4, mem[1], 32'd2, 1'b1})
                $display("FAIL stall_hold: addr=%h pc=%h instr=%h cnt=%0d want 8/4/%h/2",
                         imem_addr, if_pc, if_instr, fetch_count, mem[1]);
            else passed++;
        end
        stall = 1'b0;
        run_fetch(1);
        total++;
        if (fetch_count !== 32'd3)
            $display("FAIL stall_release_count: got %0d want 3", fetch_count);
        else passed++;
    endtask

    task automatic test_redirect_stall();
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_0010;
        step();
        stall = 1'b0;
        redirect_valid = 1'b0;
        total++;
        if ({if_valid, if_instr, imem_addr, if_pc} !==
            {1'b0, 32'd0, 32'h10, 32'd8})
            $display("FAIL redirect_bubble: v=%0b instr=%h addr=%h pc=%h want 0/0/10/8",
                     if_valid, if_instr, imem_addr, if_pc);
        else passed++;
        exp_pc = 32'h10;
        run_fetch(1);
    endtask

    task automatic test_misalign();
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_0013;
        step();
        redirect_valid = 1'b0;
        total++;
        if ({imem_addr, misalign_pulse, if_valid} !== {32'h10, 1'b1, 1'b0})
            $display("FAIL misalign_set: addr=%h pulse=%0b v=%0b want 10/1/0",
                     imem_addr, misalign_pulse, if_valid);
        else passed++;
        exp_pc = 32'h10;
        run_fetch(1);
        total++;
        if (misalign_pulse !== 1'b0)
            $display("FAIL misalign_clear: got %0b want 0", misalign_pulse);
        else passed++;
    endtask

    task automatic test_fault();
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_03F0;
        step();
        redirect_valid = 1'b0;
        exp_pc = 32'h3F0;
        run_fetch(4);
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if ({fetch_fault, if_valid, imem_addr, fetch_count, if_instr} !==
                {1'b1, 1'b0, 32'h400, exp_count, 32'd0})
                $display("FAIL fault_state: flt=%0b v=%0b addr=%h cnt=%0d want 1/0/400/%0d",
                         fetch_fault, if_valid, imem_addr, fetch_count, exp_count);
            else passed++;
        end
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_0000;
        step();
        redirect_valid = 1'b0;
        total++;
        if ({fetch_fault, if_valid, imem_addr} !== {1'b0, 1'b0, 32'd0})
            $display("FAIL fault_clear: flt=%0b v=%0b addr=%h want 0/0/0",
                     fetch_fault, if_valid, imem_addr);
        else passed++;
        exp_pc = 32'd0;
        run_fetch(2);
    endtask

    task automatic test_async_reset();
        run_fetch(2);
        stall = 1'b1;
        step();
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if ({imem_addr, if_instr, if_pc, if_pc_plus4, if_valid,
             fetch_fault, misalign_pulse, fetch_count} !== '0)
            $display("FAIL async_reset: addr=%h instr=%h pc=%h v=%0b cnt=%0d want all 0",
                     imem_addr, if_instr, if_pc, if_valid, fetch_count);
        else passed++;
        do_reset();
        run_fetch(1);
        total++;
        if (fetch_count !== 32'd1)
            $display("FAIL async_restart_count: got %0d want 1", fetch_count);
        else passed++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
        mem[0] = 32'h2008_0005;
        mem[1] = 32'h2009_0007;
        mem[2] = 32'h0109_5020;
        mem[3] = 32'hAC0A_0000;
        mem[4] = 32'h8C0B_0000;
        exp_pc = 32'd0;
        exp_count = 32'd0;
        test_reset();
        test_free_run();
        test_stall();
        test_redirect_stall();
        test_misalign();
        test_fault();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
